// File: rtl/cipher_round_ctrl_pkg.sv
// Shared types, widths and round-constant helper for the cipher round controller.
package cipher_round_ctrl_pkg;

   localparam int STATE_W = 64;
   localparam int KEY_W   = 128;
   localparam int RC_W    = 6;
   localparam logic [RC_W-1:0] RC_INIT = 6'h01;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fsm_state_t;

   // Round-constant LFSR step: shift left, feed back rc[5]^rc[4]^1.
   function automatic logic [RC_W-1:0] rc_next(input logic [RC_W-1:0] rc);
      return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
   endfunction

endpackage

// File: rtl/cipher_rc_lfsr.sv
// Round-constant generator: reloads RC_INIT at block accept, advances once per round.
module cipher_rc_lfsr
   import cipher_round_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   output logic [RC_W-1:0] rc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rc <= RC_INIT;
      end else if (load) begin
         rc <= RC_INIT;
      end else if (step) begin
         rc <= rc_next(rc);
      end
   end

endmodule

// File: rtl/cipher_round_ctrl.sv
// Iterative cipher round controller: sequences ROUNDS passes through an external round datapath.
// Optional abort input is enabled by defining CIPHER_ROUND_CTRL_ABORT_EN.
module cipher_round_ctrl
   import cipher_round_ctrl_pkg::*;
#(
   parameter int ROUNDS = 28
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] data_in,
   input  logic [KEY_W-1:0]   key_in,
   input  logic               sbox_mode,
   output logic [STATE_W-1:0] rf_a,
   output logic [31:0]        rf_key,
   output logic [RC_W-1:0]    rf_rc,
   output logic               rf_sbox_type,
   input  logic [STATE_W-1:0] rf_b,
`ifdef CIPHER_ROUND_CTRL_ABORT_EN
   input  logic               abort,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] data_out
);

   localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

   fsm_state_t         fsm_q;
   fsm_state_t         fsm_d;
   logic [STATE_W-1:0] blk_q;
   logic [KEY_W-1:0]   key_q;
   logic               mode_q;
   logic [5:0]         r_q;
   logic               abort_hit;
   logic               accept;
   logic               step;

`ifdef CIPHER_ROUND_CTRL_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   assign accept = (fsm_q == IDLE) && in_valid;
   assign step   = (fsm_q == RUN) && !abort_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q <= IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   // Abort wins over normal progress in both RUN and DONE.
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE: if (in_valid) fsm_d = RUN;
         RUN: begin
            if (abort_hit) begin
               fsm_d = IDLE;
            end else if (r_q == LAST_ROUND) begin
               fsm_d = DONE;
            end
         end
         DONE: if (abort_hit || out_ready) fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (fsm_q == IDLE);
      out_valid = (fsm_q == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk_q  <= '0;
         key_q  <= '0;
         mode_q <= 1'b0;
         r_q    <= '0;
      end else if (accept) begin
         blk_q  <= data_in;
         key_q  <= key_in;
         mode_q <= sbox_mode;
         r_q    <= '0;
      end else if (step) begin
         blk_q <= rf_b;
         r_q   <= r_q + 6'd1;
      end
   end

   cipher_rc_lfsr u_rc_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (accept),
      .step (step),
      .rc   (rf_rc)
   );

   // Round key cycles through the four latched key words.
   assign rf_key       = key_q[{r_q[1:0], 5'd0} +: 32];
   assign rf_sbox_type = mode_q & r_q[0];
   assign rf_a         = blk_q;
   assign data_out     = blk_q;

endmodule

// File: tb/tb_cipher_round_ctrl.sv
// Randomized self-checking bench for cipher_round_ctrl with a stub round datapath.
module tb_cipher_round_ctrl;

   localparam int ROUNDS = 28;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  data_in;
   logic [127:0] key_in;
   logic         sbox_mode;
   logic [63:0]  rf_a;
   logic [31:0]  rf_key;
   logic [5:0]   rf_rc;
   logic         rf_sbox_type;
   logic [63:0]  rf_b;
   logic         out_valid;
   logic         out_ready;
   logic [63:0]  data_out;
   logic         stub_inc;
`ifdef CIPHER_ROUND_CTRL_ABORT_EN
   logic         abort;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [5:0] rc_tbl [6] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E};

   function automatic logic [63:0] mixRound(input logic [63:0] a, input logic [31:0] k,
                                            input logic [5:0] rc, input logic sb);
      return ({a[62:0], a[63]} ^ {rc, 26'h0, k}) + (sb ? 64'h9E3779B9 : 64'h1);
   endfunction

   function automatic logic [5:0] modelRcNext(input logic [5:0] rc);
      return ((rc << 1) & 6'h3E) | (((rc >> 5) ^ (rc >> 4) ^ 6'd1) & 6'd1);
   endfunction

   assign rf_b = stub_inc ? rf_a + 64'd1 : mixRound(rf_a, rf_key, rf_rc, rf_sbox_type);

   cipher_round_ctrl #(.ROUNDS(ROUNDS)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .data_in      (data_in),
      .key_in       (key_in),
      .sbox_mode    (sbox_mode),
      .rf_a         (rf_a),
      .rf_key       (rf_key),
      .rf_rc        (rf_rc),
      .rf_sbox_type (rf_sbox_type),
      .rf_b         (rf_b),
`ifdef CIPHER_ROUND_CTRL_ABORT_EN
      .abort        (abort),
`endif
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .data_out     (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Offers one block, checks every round against the model, holds DONE, then releases it.
   task automatic applyStimulus(input logic [63:0] d, input logic [127:0] k, input logic m,
                                input logic inc, input int hold, output logic [63:0] result);
      logic [63:0] a;
      logic [5:0]  rc;
      logic [31:0] kw;
      logic        sb;
      @(negedge clk);
      stub_inc  = inc;
      in_valid  = 1'b1;
      data_in   = d;
      key_in    = k;
      sbox_mode = m;
      checkOutput("in_ready_idle", {63'b0, in_ready}, 64'd1);
      @(posedge clk); #1;
      a  = d;
      rc = 6'h01;
      for (int i = 0; i < ROUNDS; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         sbox_mode = 1'($urandom_range(0, 1));
         data_in   = {$urandom, $urandom};
         kw = k[(i % 4) * 32 +: 32];
         sb = m & ((i % 2) == 1);
         checkOutput("out_valid_run", {63'b0, out_valid}, 64'd0);
         checkOutput("in_ready_run", {63'b0, in_ready}, 64'd0);
         checkOutput("rf_a", rf_a, a);
         checkOutput("rf_key", {32'b0, rf_key}, {32'b0, kw});
         checkOutput("rf_rc", {58'b0, rf_rc}, {58'b0, rc});
         checkOutput("rf_sbox", {63'b0, rf_sbox_type}, {63'b0, sb});
         if (i < 6) checkOutput("rc_table", {58'b0, rf_rc}, {58'b0, rc_tbl[i]});
         a  = inc ? a + 64'd1 : mixRound(a, kw, rc, sb);
         rc = modelRcNext(rc);
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      checkOutput("out_valid_done", {63'b0, out_valid}, 64'd1);
      checkOutput("data_out", data_out, a);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         checkOutput("hold_valid", {63'b0, out_valid}, 64'd1);
         checkOutput("hold_data", data_out, a);
         checkOutput("hold_in_ready", {63'b0, in_ready}, 64'd0);
      end
      result    = data_out;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("exit_in_ready", {63'b0, in_ready}, 64'd1);
      checkOutput("exit_out_valid", {63'b0, out_valid}, 64'd0);
      in_valid = 1'b0;
   endtask

   initial begin
      logic [63:0]  res;
      logic [63:0]  d;
      logic [127:0] k;
      rst       = 1'b1;
      in_valid  = 1'b0;
      data_in   = '0;
      key_in    = '0;
      sbox_mode = 1'b0;
      out_ready = 1'b0;
      stub_inc  = 1'b1;
`ifdef CIPHER_ROUND_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd1);
      checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
      checkOutput("rst_data_out", data_out, 64'd0);
      checkOutput("rst_rc", {58'b0, rf_rc}, 64'h01);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(64'h0, 128'h33333333_22222222_11111111_00000000, 1'b1, 1'b1, 10, res);
      checkOutput("inc_result", res, 64'h1C);

      // Asynchronous reset in the middle of round 5.
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = 64'h1234;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("midrst_out_valid", {63'b0, out_valid}, 64'd0);
      checkOutput("midrst_in_ready", {63'b0, in_ready}, 64'd1);
      checkOutput("midrst_rf_a", rf_a, 64'd0);
      checkOutput("midrst_rc", {58'b0, rf_rc}, 64'h01);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(64'h0, 128'h0, 1'b0, 1'b1, 0, res);
      checkOutput("post_rst_result", res, 64'h1C);

`ifdef CIPHER_ROUND_CTRL_ABORT_EN
      @(negedge clk);
      stub_inc = 1'b1;
      in_valid = 1'b1;
      data_in  = 64'h500;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("abort_pre", rf_a, 64'h503);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checkOutput("abort_in_ready", {63'b0, in_ready}, 64'd1);
      checkOutput("abort_rf_a", rf_a, 64'h503);
      for (int i = 0; i < ROUNDS + 2; i++) begin
         checkOutput("abort_no_valid", {63'b0, out_valid}, 64'd0);
         @(posedge clk); #1;
      end
      applyStimulus(64'h77, 128'h0, 1'b0, 1'b1, 1, res);
      checkOutput("abort_next_result", res, 64'h77 + 64'h1C);
`endif

      for (int n = 0; n < 20; n++) begin
         d = {$urandom, $urandom};
         k = {$urandom, $urandom, $urandom, $urandom};
         applyStimulus(d, k, 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 4), res);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
